multiplier_sequencer: RTL

Moore-style sequencer for the shift-add datapath of the sequential signed multiplier. It accepts a one-cycle start pulse from the debounced centre button, loads operand magnitudes, and iterates test/add/shift over the multiplier magnitude. It terminates early when the remaining multiplier is zero, applies the sign fix-up, and flags completion to the display control logic. It sits between the button conditioning and the multiplier datapath, replacing ad-hoc load/step strobes with a single owner of the iteration sequence.

---
 rtl/multiplier_sequencer_if.sv | 27 ++
 rtl/multiplier_sequencer.sv | 98 +++++++++
 2 files changed

// File: rtl/multiplier_sequencer_if.sv
// Control interface between the multiplication sequencer and its surroundings:
// the button-side request/cancel, datapath status in, datapath strobes out.
interface multiplier_sequencer_if;
    logic start;
    logic abort;
    logic signA;
    logic signB;
    logic multiplierLsb;
    logic zeroFlag;
    logic loadOperands;
    logic addEnable;
    logic shiftEnable;
    logic negateResult;
    logic busy;
    logic done;

    // The sequencer owns the iteration, so it is the master of the strobes.
    modport master (
        input  start, abort, signA, signB, multiplierLsb, zeroFlag,
        output loadOperands, addEnable, shiftEnable, negateResult, busy, done
    );

    modport slave (
        output start, abort, signA, signB, multiplierLsb, zeroFlag,
        input  loadOperands, addEnable, shiftEnable, negateResult, busy, done
    );
endinterface

// File: rtl/multiplier_sequencer.sv
// Moore sequencer for a shift-add signed multiplier: load, test/add/shift per
// multiplier bit with early exit on a zero remainder, sign fix-up, then done.
module multiplier_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multiplier_sequencer_if.master bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE, LOAD, TEST, ADD, SHIFT, FIX, DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            negSign;

    // Every output is registered together with the state it belongs to, so
    // each branch sets the strobes of the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: reset is sampled on the clock edge, so it lives inside the
            // clocked branch rather than in the sensitivity list.
            state            <= IDLE;
            count            <= '0;
            negSign          <= 1'b0;
            bus.loadOperands <= 1'b0;
            bus.addEnable    <= 1'b0;
            bus.shiftEnable  <= 1'b0;
            bus.negateResult <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so these defaults are simply
            // overridden by the later assignments of the taken branch.
            bus.loadOperands <= 1'b0;
            bus.addEnable    <= 1'b0;
            bus.shiftEnable  <= 1'b0;
            bus.negateResult <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;

            if (bus.abort) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            state            <= LOAD;
                            negSign          <= bus.signA ^ bus.signB;
                            bus.loadOperands <= 1'b1;
                            bus.busy         <= 1'b1;
                        end else begin
                            bus.done <= (state == DONE);
                        end
                    end
                    LOAD: begin
                        state    <= TEST;
                        count    <= '0;
                        bus.busy <= 1'b1;
                    end
                    TEST: begin
                        bus.busy <= 1'b1;
                        // The count limit also guarantees count never passes WIDTH.
                        if (bus.zeroFlag || count == LIMIT) begin
                            state            <= FIX;
                            bus.negateResult <= negSign;
                        end else if (bus.multiplierLsb) begin
                            state         <= ADD;
                            bus.addEnable <= 1'b1;
                        end else begin
                            state           <= SHIFT;
                            bus.shiftEnable <= 1'b1;
                        end
                    end
                    ADD: begin
                        state           <= SHIFT;
                        bus.shiftEnable <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                    SHIFT: begin
                        state    <= TEST;
                        count    <= count + CW'(1);
                        bus.busy <= 1'b1;
                    end
                    FIX: begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
